lfsr_burst_ctrl: RTL and testbench

//  Sequencer wrapped around a Fibonacci LFSR. On start it seeds the LFSR and runs a burst of
//  `len` pseudo-random words. Each word is presented on a valid/ready stream and the LFSR

---
 rtl/lfsr_burst_ctrl.sv | 76 +++++++
 tb/tb_lfsr_burst_ctrl.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/lfsr_burst_ctrl.sv
// lfsr_burst_ctrl: start/abort sequencer that streams a burst of Fibonacci LFSR words over valid/ready.
// Optional zero-seed guard enabled by defining LFSR_ZERO_GUARD_EN.
module lfsr_burst_ctrl #(
    parameter int              WIDTH        = 4,
    parameter logic [WIDTH-1:0] TAPS         = 4'b1100,
    parameter int              CNT_W        = 8,
    parameter logic [WIDTH-1:0] DEFAULT_SEED = 4'b0001
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] seed,
    input  logic [CNT_W-1:0] len,
    input  logic             abort,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic             seed_err
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] lfsr_q, lfsr_d, seed_q, load_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, len_q;
    logic             xfer;

    assign lfsr_d    = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};
    assign cnt_d     = cnt_q + 1'b1;
    assign xfer      = (state_q == RUN) && out_ready;
    assign out_data  = lfsr_q;
    assign out_valid = (state_q == RUN);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);

`ifdef LFSR_ZERO_GUARD_EN
    // An all-zero seed would lock the LFSR, so substitute the reset seed and flag it.
    assign load_d   = (seed_q == '0) ? DEFAULT_SEED : seed_q;
    assign seed_err = (state_q == LOAD) && (seed_q == '0);
`else
    assign load_d   = seed_q;
    assign seed_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            lfsr_q  <= DEFAULT_SEED;
            cnt_q   <= '0;
            seed_q  <= '0;
            len_q   <= '0;
        end else begin
            if (xfer) lfsr_q <= lfsr_d;
            case (state_q)
                IDLE: if (start) begin
                    seed_q  <= seed;
                    len_q   <= len;
                    state_q <= (len == '0) ? DONE : LOAD;
                end
                LOAD: if (abort) state_q <= IDLE;
                else begin
                    lfsr_q  <= load_d;
                    cnt_q   <= '0;
                    state_q <= RUN;
                end
                RUN: if (abort) state_q <= IDLE;
                else if (xfer) begin
                    cnt_q <= cnt_d;
                    if (cnt_d == len_q) state_q <= DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lfsr_burst_ctrl.sv
// tb_lfsr_burst_ctrl: randomized bursts checked against a table-driven model of the LFSR sequence.
module tb_lfsr_burst_ctrl;
    logic       clk = 0, reset = 0, start = 0, abort = 0, out_ready = 0;
    logic [3:0] seed = 0;
    logic [7:0] len = 0;
    logic [3:0] out_data;
    logic       out_valid, busy, done, seed_err;
    int         errs = 0, checks = 0;
    logic [3:0] mdl;
    logic [3:0] cyc [15] = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hd, 4'ha,
                             4'h5, 4'hb, 4'h7, 4'hf, 4'he, 4'hc, 4'h8};
`ifdef LFSR_ZERO_GUARD_EN
    bit guard = 1;
`else
    bit guard = 0;
`endif

    lfsr_burst_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .seed(seed), .len(len), .abort(abort),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done), .seed_err(seed_err)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] nxt(input logic [3:0] x);
        for (int i = 0; i < 15; i++) if (cyc[i] == x) return cyc[(i + 1) % 15];
        return x;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ab_at: abort in the cycle where that many transfers are already done (-1 = never).
    // poke: keep start high while busy and through DONE to show it is ignored.
    task automatic burst(input logic [3:0] s, input logic [7:0] l, input int pct,
                         input int ab_at, input bit poke);
        logic [3:0] w;
        int k, n;
        bit aborted;
        @(negedge clk);
        start = 1; seed = s; len = l;
        @(posedge clk);
        @(negedge clk);
        if (!poke) start = 0;
        seed = 4'($urandom); len = 8'($urandom);
        if (l == 0) begin
            chk("zlen_done", done, 1);
            chk("zlen_valid", out_valid, 0);
            chk("zlen_busy", busy, 1);
            @(posedge clk);
            @(negedge clk);
            chk("zlen_idle", busy, 0);
            chk("zlen_done_end", done, 0);
            chk("zlen_data", out_data, mdl);
            start = 0;
            return;
        end
        chk("load_busy", busy, 1);
        chk("load_valid", out_valid, 0);
        chk("load_seed_err", seed_err, guard && s == 0);
        w = (guard && s == 0) ? 4'h1 : s;
        k = 0; n = 0; aborted = 0;
        @(posedge clk);
        while (k < l && !aborted) begin
            @(negedge clk);
            chk("run_valid", out_valid, 1);
            chk("run_data", out_data, w);
            chk("run_done", done, 0);
            chk("run_seed_err", seed_err, 0);
            out_ready = ($urandom_range(99) < pct);
            abort = (ab_at == k);
            @(posedge clk);
            if (out_ready) begin w = nxt(w); k++; end
            if (abort) aborted = 1;
            if (++n > 3000) begin
                chk("timeout", k, l);
                break;
            end
        end
        @(negedge clk);
        abort = 0; out_ready = 1'($urandom);
        mdl = w;
        chk("post_valid", out_valid, 0);
        chk("post_data", out_data, w);
        if (aborted) begin
            chk("abort_busy", busy, 0);
            chk("abort_done", done, 0);
        end else begin
            chk("done_pulse", done, 1);
            chk("done_busy", busy, 1);
            @(posedge clk);
            @(negedge clk);
            chk("idle_busy", busy, 0);
            chk("idle_done", done, 0);
        end
        start = 0;
    endtask

    initial begin
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_seed_err", seed_err, 0);
        chk("rst_data", out_data, 4'h1);
        @(negedge clk);
        reset = 1; mdl = 4'h1;
        burst(4'h1, 8'd5, 100, -1, 0);
        burst(4'h1, 8'd5, 50, -1, 0);
        burst(4'h9, 8'd0, 100, -1, 0);
        burst(4'h3, 8'd10, 70, 2, 1);
        burst(4'h0, 8'd3, 100, -1, 0);
        burst(4'h6, 8'd40, 80, -1, 1);
        for (int i = 0; i < 10; i++) begin
            logic [7:0] l;
            l = 8'($urandom_range(1, 20));
            burst(4'($urandom), l, $urandom_range(30, 100),
                  ($urandom_range(3) == 0) ? int'($urandom_range(0, l - 1)) : -1,
                  1'($urandom));
        end
        burst(4'hb, 8'd0, 100, -1, 0);
        @(negedge clk);
        start = 1; seed = 4'h5; len = 8'd20; out_ready = 1;
        repeat (4) @(posedge clk);
        start = 0;
        #2 reset = 0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_data", out_data, 4'h1);
        @(negedge clk);
        reset = 1; mdl = 4'h1;
        @(negedge clk);
        chk("arst_idle", busy, 0);
        burst(4'h7, 8'd4, 100, -1, 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
